counter_bank_strobe: RTL and testbench
======================================

// Module: counter_bank_strobe
// PURPOSE
//  Bank of CHANNELS independent event counters, each pulsing a 1-cycle strobe after a
//  programmable number of accepted enable events. Next generation of our single-channel
//  strobe counter: per-channel period, periodic or one-shot mode, glitch-free period
//  reload and an error flag for enables that violate ready.
//  Sits between tick sources (prescalers, edge detectors) and FSMs needing divided events.
// PARAMETERS
//  WIDTH     8   counter/period width per channel (2..32)
//  CHANNELS  4   number of independent channels (1..16)
//  LATENCY   2   min cycles between accepted enables of one channel (1..4)
// PORTS
//  clk          in   1               single clock, all logic on posedge
//  rst          in   1               synchronous, active-high reset; whole bank
//  enable       in   CHANNELS        per-channel event pulse
//  period       in   CHANNELS*WIDTH  flattened periods; ch i = period[i*WIDTH +: WIDTH]
//  mode         in   CHANNELS        0 = periodic, 1 = one-shot
//  arm          in   CHANNELS        one-shot re-arm pulse
//  strobe       out  CHANNELS        1-cycle terminal-count pulse
//  ready        out  CHANNELS        channel may accept an enable this cycle
//  done         out  CHANNELS        one-shot channel has fired, idle until arm
//  err          out  CHANNELS        1-cycle pulse: enable arrived while !ready or done
// BEHAVIOUR
//  Reset: cnt=0, shadow period loaded from period, strobe=0, done=0, err=0, ready=0;
//   ready rises LATENCY cycles after rst deasserts.
//  ready[i] = (cycles since last accepted enable or rst >= LATENCY) && !done[i].
//  Accepted enable: enable[i] && ready[i]. Non-accepted enable: no count change,
//   err[i]=1 next cycle.
//  On accept: if cnt+1 == shadow (mod 2^WIDTH) -> strobe[i]=1 next cycle, cnt<=0,
//   shadow<=period[i] (reload only at terminal count; mid-count period changes ignored);
//   else cnt<=cnt+1. ready tracker restarts on every accept.
//  Latency: strobe registered, exactly 1 cycle after the terminal enable; never 2 wide.
//  Period 1: strobe after every accepted enable. Period 0: 2^WIDTH enables (full wrap).
//  mode sampled at terminal count: 1 -> done[i]=1 same edge as strobe; 0 -> keep counting.
//  arm[i]: cnt<=0, done<=0, shadow<=period[i], tracker restarts (ready after LATENCY).
//  arm && enable same cycle: arm wins, enable dropped, no err.
//  arm while not done: acts as a count restart.
//  rst mid-count: all state reset as above; enable during rst ignored, no err.
//  Channels fully independent; simultaneous strobes on any subset legal.
//  Per-channel FSM: IDLE(!ready) -> READY on tracker>=LATENCY; READY -> IDLE on accept;
//   any -> DONE on one-shot terminal; DONE -> IDLE on arm.
// STRUCTURE
//  Shared include counter_defs.vh: MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1, state encodings
//   ST_IDLE/ST_READY/ST_DONE, tracker width localparam ($clog2(LATENCY+1)).
//  Sub-module counter_strobe_channel (one counter, shadow, tracker, FSM), instanced
//   CHANNELS times in a generate loop; top is slicing and concatenation only.
//  Terminal compare may be pipelined up to LATENCY-1 stages; strobe latency stays 1.
// TESTING
//  T1 W=8,ch0 period=3 periodic, enable every 3 cycles -> strobe 1 cycle after 3rd,
//   6th, 9th enable; cnt back to 0 each time.
//  T2 ch1 period=0, W=4 -> strobe after exactly 16 accepted enables, not 15.
//  T3 ch2 one-shot period=2 -> strobe+done after 2nd enable; 3rd enable gives err=1,
//   no strobe; arm -> done=0, ready after LATENCY, next 2 enables strobe again.
//  T4 back-to-back enables with LATENCY=2 -> 2nd enable err=1 and not counted.
//  T5 change period 5->2 after 1st enable -> terminal still at 5th; next cycle at 2nd.
//  T6 rst asserted at cnt=2 with enable high, plus arm&&enable collision -> all outputs
//   0, no err; collision drops enable; all 4 channels strobing same cycle verified.

Source files
------------

// File: rtl/counter_bank_strobe_pkg.sv
// Shared definitions for the strobe counter bank: mode encodings, per-channel
// FSM states and the ready-tracker width helper.
package counter_bank_strobe_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_DONE  = 2'd2
  } chan_state_t;

  // Tracker holds 0..LATENCY and saturates at LATENCY.
  function automatic int trk_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/counter_bank_strobe_channel.sv
// One strobe counter channel: event counter, shadow period, ready tracker and
// the IDLE/READY/DONE control FSM.
module counter_bank_strobe_channel
  import counter_bank_strobe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] period,
  input  logic             mode,
  input  logic             arm,
  output logic             strobe,
  output logic             ready,
  output logic             done,
  output logic             err
);

  localparam int TRK_W = trk_width(LATENCY);
  localparam logic [TRK_W-1:0] LAT_T   = TRK_W'(LATENCY);
  localparam logic [TRK_W-1:0] TRK_ONE = TRK_W'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  chan_state_t      state_reg, state_next, restart_state;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] shadow_reg, shadow_next;
  logic [TRK_W-1:0] trk_reg, trk_next;
  logic             strobe_reg, strobe_next;
  logic             err_reg, err_next;
  logic             accept;
  logic             terminal;

  assign accept   = enable && (state_reg == ST_READY) && !arm;
  // Compare wraps mod 2^WIDTH, so a period of 0 means a full 2^WIDTH count.
  assign terminal = (cnt_reg + CNT_ONE) == shadow_reg;
  // The cycle right after an accept/arm already counts as one elapsed cycle.
  assign restart_state = (TRK_ONE >= LAT_T) ? ST_READY : ST_IDLE;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shadow_next = shadow_reg;
    trk_next    = trk_reg;
    strobe_next = 1'b0;
    err_next    = 1'b0;
    if (arm) begin
      // Arm beats a same-cycle enable and raises no error.
      cnt_next    = '0;
      shadow_next = period;
      trk_next    = TRK_ONE;
      state_next  = restart_state;
    end else begin
      err_next = enable && !accept;
      case (state_reg)
        ST_IDLE: begin
          if (trk_reg < LAT_T) trk_next = trk_reg + TRK_ONE;
          if (trk_next >= LAT_T) state_next = ST_READY;
        end
        ST_READY: begin
          if (accept) begin
            trk_next = TRK_ONE;
            if (terminal) begin
              strobe_next = 1'b1;
              cnt_next    = '0;
              shadow_next = period;
              case (mode)
                MODE_PERIODIC: state_next = restart_state;
                MODE_ONESHOT:  state_next = ST_DONE;
                default:       state_next = restart_state;
              endcase
            end else begin
              cnt_next   = cnt_reg + CNT_ONE;
              state_next = restart_state;
            end
          end
        end
        ST_DONE: state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      shadow_reg <= period;
      trk_reg    <= '0;
      strobe_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shadow_reg <= shadow_next;
      trk_reg    <= trk_next;
      strobe_reg <= strobe_next;
      err_reg    <= err_next;
    end
  end

  assign strobe = strobe_reg;
  assign err    = err_reg;
  assign ready  = (state_reg == ST_READY);
  assign done   = (state_reg == ST_DONE);

endmodule

// File: rtl/counter_bank_strobe.sv
// Bank of independent strobe counters; the top only slices the flattened
// period bus and fans the per-channel controls out to each channel.
module counter_bank_strobe
  import counter_bank_strobe_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS*WIDTH-1:0] period,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       arm,
  output logic [CHANNELS-1:0]       strobe,
  output logic [CHANNELS-1:0]       ready,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       err
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    counter_bank_strobe_channel #(
      .WIDTH   (WIDTH),
      .LATENCY (LATENCY)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .enable (enable[gi]),
      .period (period[gi*WIDTH +: WIDTH]),
      .mode   (mode[gi]),
      .arm    (arm[gi]),
      .strobe (strobe[gi]),
      .ready  (ready[gi]),
      .done   (done[gi]),
      .err    (err[gi])
    );
  end

endmodule

// File: tb/tb_counter_bank_strobe.sv
// Directed bench for counter_bank_strobe: an 8-bit 4-channel bank plus a 4-bit
// 2-channel bank for the full-wrap case.
module tb_counter_bank_strobe;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  enable, mode, arm;
  logic [31:0] period;
  logic [3:0]  strobe, ready, done, err;
  logic [1:0]  enable4, mode4, arm4;
  logic [7:0]  period4;
  logic [1:0]  strobe4, ready4, done4, err4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_bank_strobe #(.WIDTH(8), .CHANNELS(4), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .mode(mode),
    .arm(arm), .strobe(strobe), .ready(ready), .done(done), .err(err)
  );

  counter_bank_strobe #(.WIDTH(4), .CHANNELS(2), .LATENCY(2)) dut4 (
    .clk(clk), .rst(rst), .enable(enable4), .period(period4), .mode(mode4),
    .arm(arm4), .strobe(strobe4), .ready(ready4), .done(done4), .err(err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = '0; arm = '0; enable4 = '0; arm4 = '0;
    period = {8'd4, 8'd2, 8'd2, 8'd3};
    mode = 4'b0100;
    period4 = {4'd0, 4'd5};
    mode4 = 2'b00;
    tick(); tick();
    checks++;
    if ({strobe, done, err, ready} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000", {strobe, done, err, ready});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_early: got %b expected 0000", ready);
    end
    tick();
    checks++;
    if (ready !== 4'b1111 || ready4 !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b/%b expected 1111/11", ready, ready4);
    end
    $display("test_reset done");
  endtask

  task automatic test_periodic();
    for (int k = 1; k <= 9; k++) begin
      logic exp;
      exp = (k % 3 == 0);
      enable[0] = 1'b1;
      tick();
      enable[0] = 1'b0;
      checks++;
      if (strobe[0] !== exp || err[0] !== 1'b0) begin
        errors++;
        $display("FAIL periodic_enable%0d: strobe=%b err=%b expected strobe=%b err=0",
                 k, strobe[0], err[0], exp);
      end
      tick();
      checks++;
      if (strobe[0] !== 1'b0) begin
        errors++;
        $display("FAIL periodic_width%0d: strobe=%b expected 0", k, strobe[0]);
      end
      tick();
    end
    $display("test_periodic done");
  endtask

  task automatic test_full_wrap();
    for (int k = 1; k <= 16; k++) begin
      logic exp;
      exp = (k == 16);
      enable4[1] = 1'b1;
      tick();
      enable4[1] = 1'b0;
      checks++;
      if (strobe4[1] !== exp || err4[1] !== 1'b0) begin
        errors++;
        $display("FAIL wrap_enable%0d: strobe=%b err=%b expected strobe=%b err=0",
                 k, strobe4[1], err4[1], exp);
      end
      tick();
    end
    $display("test_full_wrap done");
  endtask

  task automatic test_oneshot();
    enable[2] = 1'b1; tick(); enable[2] = 1'b0;
    checks++;
    if (strobe[2] !== 1'b0 || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_first: strobe=%b done=%b expected 0/0", strobe[2], done[2]);
    end
    tick();
    enable[2] = 1'b1; tick(); enable[2] = 1'b0;
    checks++;
    if (strobe[2] !== 1'b1 || done[2] !== 1'b1 || ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_fire: strobe=%b done=%b ready=%b expected 1/1/0",
               strobe[2], done[2], ready[2]);
    end
    tick();
    enable[2] = 1'b1; tick(); enable[2] = 1'b0;
    checks++;
    if (err[2] !== 1'b1 || strobe[2] !== 1'b0 || done[2] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_done_enable: err=%b strobe=%b done=%b expected 1/0/1",
               err[2], strobe[2], done[2]);
    end
    tick();
    checks++;
    if (err[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_err_width: err=%b expected 0", err[2]);
    end
    arm[2] = 1'b1; tick(); arm[2] = 1'b0;
    checks++;
    if (done[2] !== 1'b0 || ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_arm: done=%b ready=%b expected 0/0", done[2], ready[2]);
    end
    tick();
    checks++;
    if (ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_arm_ready: ready=%b expected 1", ready[2]);
    end
    for (int k = 1; k <= 2; k++) begin
      logic exp;
      exp = (k == 2);
      enable[2] = 1'b1; tick(); enable[2] = 1'b0;
      checks++;
      if (strobe[2] !== exp || done[2] !== exp) begin
        errors++;
        $display("FAIL oneshot_rearm%0d: strobe=%b done=%b expected %b/%b",
                 k, strobe[2], done[2], exp, exp);
      end
      tick();
    end
    $display("test_oneshot done");
  endtask

  task automatic test_back_to_back();
    enable[3] = 1'b1;
    tick();
    checks++;
    if (err[3] !== 1'b0 || ready[3] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: err=%b ready=%b expected 0/0", err[3], ready[3]);
    end
    tick();
    enable[3] = 1'b0;
    checks++;
    if (err[3] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_err: err=%b expected 1", err[3]);
    end
    tick();
    // One accepted so far; the rejected enable must not count toward 4.
    for (int k = 2; k <= 4; k++) begin
      logic exp;
      exp = (k == 4);
      enable[3] = 1'b1; tick(); enable[3] = 1'b0;
      checks++;
      if (strobe[3] !== exp || err[3] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_count%0d: strobe=%b err=%b expected %b/0", k, strobe[3], err[3], exp);
      end
      tick();
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_period_change();
    period[7:0] = 8'd5;
    arm[0] = 1'b1; tick(); arm[0] = 1'b0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      logic exp;
      exp = (k == 5);
      enable[0] = 1'b1; tick(); enable[0] = 1'b0;
      if (k == 1) period[7:0] = 8'd2;
      checks++;
      if (strobe[0] !== exp) begin
        errors++;
        $display("FAIL period_hold%0d: strobe=%b expected %b", k, strobe[0], exp);
      end
      tick();
    end
    for (int k = 1; k <= 2; k++) begin
      logic exp;
      exp = (k == 2);
      enable[0] = 1'b1; tick(); enable[0] = 1'b0;
      checks++;
      if (strobe[0] !== exp) begin
        errors++;
        $display("FAIL period_reload%0d: strobe=%b expected %b", k, strobe[0], exp);
      end
      tick();
    end
    $display("test_period_change done");
  endtask

  task automatic test_collision_and_reset();
    arm[1] = 1'b1; enable[1] = 1'b1;
    tick();
    arm[1] = 1'b0; enable[1] = 1'b0;
    checks++;
    if (err[1] !== 1'b0 || strobe[1] !== 1'b0 || ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL collision: err=%b strobe=%b ready=%b expected 0/0/0",
               err[1], strobe[1], ready[1]);
    end
    tick();
    for (int k = 1; k <= 2; k++) begin
      logic exp;
      exp = (k == 2);
      enable[1] = 1'b1; tick(); enable[1] = 1'b0;
      checks++;
      if (strobe[1] !== exp) begin
        errors++;
        $display("FAIL collision_count%0d: strobe=%b expected %b", k, strobe[1], exp);
      end
      tick();
    end
    // Bring ch0 to cnt=2 of 4, then reset with enables high.
    period[7:0] = 8'd4;
    arm[0] = 1'b1; tick(); arm[0] = 1'b0; tick();
    for (int k = 1; k <= 2; k++) begin
      enable[0] = 1'b1; tick(); enable[0] = 1'b0; tick();
    end
    period = {4{8'd2}};
    mode = 4'b0000;
    rst = 1'b1; enable = 4'b1111;
    tick();
    checks++;
    if ({strobe, err, done, ready} !== 16'h0) begin
      errors++;
      $display("FAIL reset_midcount: got %h expected 0000", {strobe, err, done, ready});
    end
    rst = 1'b0; enable = 4'b0000;
    tick();
    tick();
    checks++;
    if (ready !== 4'b1111) begin
      errors++;
      $display("FAIL reset_midcount_ready: got %b expected 1111", ready);
    end
    enable = 4'b1111; tick(); enable = 4'b0000;
    checks++;
    if (strobe !== 4'b0000 || err !== 4'b0000) begin
      errors++;
      $display("FAIL all_first: strobe=%b err=%b expected 0000/0000", strobe, err);
    end
    tick();
    enable = 4'b1111; tick(); enable = 4'b0000;
    checks++;
    if (strobe !== 4'b1111) begin
      errors++;
      $display("FAIL all_strobe: strobe=%b expected 1111", strobe);
    end
    tick();
    checks++;
    if (strobe !== 4'b0000) begin
      errors++;
      $display("FAIL all_strobe_width: strobe=%b expected 0000", strobe);
    end
    $display("test_collision_and_reset done");
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_full_wrap();
    test_oneshot();
    test_back_to_back();
    test_period_change();
    test_collision_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
